// File: rtl/paddle_collider.sv
// Sequential ball/paddle collider: snapshots positions on a check strobe, scans one
// paddle per clock, and reports the first newly armed paddle hit plus the hit offset.
module paddle_collider #(
  parameter int                    NPADDLES   = 2,
  parameter int                    W          = 10,
  parameter int                    IDXW       = 3,
  parameter logic [NPADDLES*W-1:0] PX_LIST    = {10'd624, 10'd0},
  parameter int                    PW         = 16,
  parameter int                    PADDLESIZE = 64,
  parameter int                    BALLSIZE   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  check,
  input  logic [W-1:0]          bx,
  input  logic [W-1:0]          by,
  input  logic [NPADDLES*W-1:0] ptop,
  output logic                  busy,
  output logic                  done,
  output logic                  hit,
  output logic [IDXW-1:0]       hit_idx,
  output logic signed [W:0]     hit_off,
  output logic [NPADDLES-1:0]   overlap
);

  localparam logic [W:0]      HALF_E   = (W+1)'(BALLSIZE / 2);
  localparam logic [W:0]      PW_E     = (W+1)'(PW);
  localparam logic [W:0]      PSZM1_E  = (W+1)'(PADDLESIZE - 1);
  localparam logic [W:0]      PMID_E   = (W+1)'(PADDLESIZE / 2);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPADDLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [NPADDLES-1:0]   arm_q, arm_d;
  logic [W-1:0]          bx_q, bx_d;
  logic [W-1:0]          by_q, by_d;
  logic [NPADDLES*W-1:0] ptop_q, ptop_d;
  logic                  cand_vld_q, cand_vld_d;
  logic [IDXW-1:0]       cand_idx_q, cand_idx_d;
  logic signed [W:0]     cand_off_q, cand_off_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  hit_q, hit_d;
  logic [IDXW-1:0]       hit_idx_q, hit_idx_d;
  logic signed [W:0]     hit_off_q, hit_off_d;
  logic [NPADDLES-1:0]   overlap_q, overlap_d;

  logic [W-1:0]          sel_px_s;
  logic [W-1:0]          sel_ptop_s;
  logic                  sel_arm_s;
  logic [W:0]            bx_e_s, by_e_s, px_e_s, pt_e_s, by_lo_s;
  logic                  ov_s;
  logic                  new_cand_s;
  logic signed [W:0]     off_s;

  // Pick the paddle currently under scan from the shadow registers.
  always_comb begin
    sel_px_s   = '0;
    sel_ptop_s = '0;
    sel_arm_s  = 1'b0;
    for (int p = 0; p < NPADDLES; p++) begin
      if (idx_q == IDXW'(p)) begin
        sel_px_s   = PX_LIST[p*W +: W];
        sel_ptop_s = ptop_q[p*W +: W];
        sel_arm_s  = arm_q[p];
      end else begin
        sel_arm_s  = sel_arm_s;
      end
    end
  end

  // Overlap test and face offset, all at W+1 bits so nothing wraps near the top edge.
  always_comb begin
    bx_e_s     = {1'b0, bx_q};
    by_e_s     = {1'b0, by_q};
    px_e_s     = {1'b0, sel_px_s};
    pt_e_s     = {1'b0, sel_ptop_s};
    by_lo_s    = (by_e_s < HALF_E) ? '0 : (by_e_s - HALF_E);
    ov_s       = (bx_e_s >= px_e_s) && (bx_e_s <= (px_e_s + PW_E)) &&
                 ((by_e_s + HALF_E) >= pt_e_s) && (by_lo_s <= (pt_e_s + PSZM1_E));
    off_s      = $signed(by_e_s - (pt_e_s + PMID_E));
    new_cand_s = ov_s && sel_arm_s && !cand_vld_q;
  end

  // Scan sequencer: next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    arm_d      = arm_q;
    bx_d       = bx_q;
    by_d       = by_q;
    ptop_d     = ptop_q;
    cand_vld_d = cand_vld_q;
    cand_idx_d = cand_idx_q;
    cand_off_d = cand_off_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hit_d      = 1'b0;
    hit_idx_d  = hit_idx_q;
    hit_off_d  = hit_off_q;
    overlap_d  = overlap_q;
    case (state_q)
      S_IDLE: begin
        if (check) begin
          bx_d       = bx;
          by_d       = by;
          ptop_d     = ptop;
          idx_d      = '0;
          cand_vld_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = S_SCAN;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_SCAN: begin
        // A paddle disarms on overlap and re-arms on the first scan where it is clear.
        for (int p = 0; p < NPADDLES; p++) begin
          if (idx_q == IDXW'(p)) begin
            overlap_d[p] = ov_s;
            arm_d[p]     = !ov_s;
          end else begin
            overlap_d[p] = overlap_q[p];
          end
        end
        if (new_cand_s) begin
          cand_vld_d = 1'b1;
          cand_idx_d = idx_q;
          cand_off_d = off_s;
        end else begin
          cand_vld_d = cand_vld_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (new_cand_s) begin
            hit_d     = 1'b1;
            hit_idx_d = idx_q;
            hit_off_d = off_s;
          end else if (cand_vld_q) begin
            hit_d     = 1'b1;
            hit_idx_d = cand_idx_q;
            hit_off_d = cand_off_q;
          end else begin
            hit_d     = 1'b0;
          end
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and re-arms every paddle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      arm_q      <= '1;
      bx_q       <= '0;
      by_q       <= '0;
      ptop_q     <= '0;
      cand_vld_q <= 1'b0;
      cand_idx_q <= '0;
      cand_off_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hit_q      <= 1'b0;
      hit_idx_q  <= '0;
      hit_off_q  <= '0;
      overlap_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      arm_q      <= arm_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      ptop_q     <= ptop_d;
      cand_vld_q <= cand_vld_d;
      cand_idx_q <= cand_idx_d;
      cand_off_q <= cand_off_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      hit_idx_q  <= hit_idx_d;
      hit_off_q  <= hit_off_d;
      overlap_q  <= overlap_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hit     = hit_q;
  assign hit_idx = hit_idx_q;
  assign hit_off = hit_off_q;
  assign overlap = overlap_q;

endmodule

// File: tb/tb_paddle_collider.sv
// Table-driven bench for paddle_collider: expected results queued at check time and
// compared on each done pulse, plus hand sequences for mid-scan checks and reset.
module tb_paddle_collider;

  logic               clk = 1'b0;
  logic               reset;
  logic               check;
  logic [9:0]         bx, by;
  logic [19:0]        ptop;
  logic               busy, done, hit;
  logic [2:0]         hit_idx;
  logic signed [10:0] hit_off;
  logic [1:0]         overlap;

  typedef struct {
    logic [9:0]         bx, by, p0, p1;
    logic               hit;
    logic [2:0]         idx;
    logic signed [10:0] off;
    logic [1:0]         ov;
  } vec_t;

  typedef struct {
    logic               hit;
    logic [2:0]         idx;
    logic signed [10:0] off;
    logic [1:0]         ov;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[23];
  int   n_tests = 0;
  int   n_fail  = 0;

  paddle_collider dut (
    .clk(clk), .reset(reset), .check(check), .bx(bx), .by(by), .ptop(ptop),
    .busy(busy), .done(done), .hit(hit), .hit_idx(hit_idx), .hit_off(hit_off),
    .overlap(overlap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Scoreboard: every done pulse consumes one queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("hit", hit, e.hit);
        chk("hit_idx", hit_idx, e.idx);
        chk("hit_off", hit_off, e.off);
        chk("overlap", overlap, e.ov);
      end
    end
  end

  task automatic run_check(input vec_t v);
    exp_t e;
    int   n;
    bit   got;
    @(negedge clk);
    bx = v.bx; by = v.by; ptop = {v.p1, v.p0}; check = 1'b1;
    e.hit = v.hit; e.idx = v.idx; e.off = v.off; e.ov = v.ov;
    sb.push_back(e);
    n = 0; got = 1'b0;
    while (n < 10 && !got) begin
      @(negedge clk);
      n++;
      check = 1'b0;
      if (n == 1) chk("busy_t1", busy, 1);
      if (done === 1'b1) got = 1'b1;
    end
    chk("latency", got ? n : -1, 3);
    @(negedge clk);
    chk("busy_after", busy, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, ndone, first_n;
    vec_t v;

    vecs[0]  = '{10'd8,   10'd232,  10'd200,  10'd300, 1'b1, 3'd0, 11'sd0,   2'b01};
    vecs[1]  = '{10'd8,   10'd232,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd0,   2'b01};
    vecs[2]  = '{10'd320, 10'd232,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd0,   2'b00};
    vecs[3]  = '{10'd8,   10'd232,  10'd200,  10'd300, 1'b1, 3'd0, 11'sd0,   2'b01};
    vecs[4]  = '{10'd320, 10'd232,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd0,   2'b00};
    vecs[5]  = '{10'd4,   10'd2,    10'd0,    10'd300, 1'b1, 3'd0, -11'sd30, 2'b01};
    vecs[6]  = '{10'd320, 10'd2,    10'd0,    10'd300, 1'b0, 3'd0, -11'sd30, 2'b00};
    vecs[7]  = '{10'd4,   10'd2,    10'd100,  10'd300, 1'b0, 3'd0, -11'sd30, 2'b00};
    vecs[8]  = '{10'd16,  10'd196,  10'd200,  10'd300, 1'b1, 3'd0, -11'sd36, 2'b01};
    vecs[9]  = '{10'd320, 10'd196,  10'd200,  10'd300, 1'b0, 3'd0, -11'sd36, 2'b00};
    vecs[10] = '{10'd16,  10'd195,  10'd200,  10'd300, 1'b0, 3'd0, -11'sd36, 2'b00};
    vecs[11] = '{10'd16,  10'd267,  10'd200,  10'd300, 1'b1, 3'd0, 11'sd35,  2'b01};
    vecs[12] = '{10'd320, 10'd267,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd35,  2'b00};
    vecs[13] = '{10'd16,  10'd268,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd35,  2'b00};
    vecs[14] = '{10'd17,  10'd232,  10'd200,  10'd300, 1'b0, 3'd0, 11'sd35,  2'b00};
    vecs[15] = '{10'd630, 10'd332,  10'd200,  10'd300, 1'b1, 3'd1, 11'sd0,   2'b10};
    vecs[16] = '{10'd640, 10'd340,  10'd200,  10'd300, 1'b0, 3'd1, 11'sd0,   2'b10};
    vecs[17] = '{10'd641, 10'd340,  10'd200,  10'd300, 1'b0, 3'd1, 11'sd0,   2'b00};
    vecs[18] = '{10'd640, 10'd299,  10'd200,  10'd300, 1'b1, 3'd1, -11'sd33, 2'b10};
    vecs[19] = '{10'd8,   10'd1023, 10'd1000, 10'd300, 1'b1, 3'd0, -11'sd9,  2'b01};
    vecs[20] = '{10'd320, 10'd232,  10'd200,  10'd300, 1'b0, 3'd0, -11'sd9,  2'b00};
    vecs[21] = '{10'd8,   10'd0,    10'd0,    10'd300, 1'b1, 3'd0, -11'sd32, 2'b01};
    vecs[22] = '{10'd320, 10'd0,    10'd0,    10'd300, 1'b0, 3'd0, -11'sd32, 2'b00};

    reset = 1'b1; check = 1'b0; bx = '0; by = '0; ptop = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_hit_idx", hit_idx, 0);
    chk("rst_hit_off", hit_off, 0);
    chk("rst_overlap", overlap, 0);
    reset = 1'b0;

    for (int i = 0; i < 23; i++) run_check(vecs[i]);

    // Repeated check strobes through the scan and DONE, with by changed mid-scan.
    @(negedge clk);
    bx = 10'd8; by = 10'd232; ptop = {10'd300, 10'd200}; check = 1'b1;
    sb.push_back('{1'b1, 3'd0, 11'sd0, 2'b01});
    n = 0; ndone = 0; first_n = -1;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) by = 10'd500;
      if (n == 4) check = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first_n < 0) first_n = n;
      end
    end
    chk("ignored_checks_done_count", ndone, 1);
    chk("ignored_checks_latency", first_n, 3);

    // Reset in the middle of a scan that would report a hit.
    v = '{10'd640, 10'd299, 10'd200, 10'd300, 1'b1, 3'd1, -11'sd33, 2'b10};
    run_check(v);
    @(negedge clk);
    bx = 10'd8; by = 10'd232; ptop = {10'd300, 10'd200}; check = 1'b1;
    @(negedge clk);
    check = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_hit_idx", hit_idx, 0);
    chk("midrst_hit_off", hit_off, 0);
    chk("midrst_overlap", overlap, 0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    chk("midrst_idle_busy", busy, 0);
    run_check(v);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
